switch_allocator: RTL and testbench

- Sits directly downstream of the five-port input buffer stage in each mesh router.
- Consumes each input unit's request, head destination and tail flag, computes the XY output port, and arbitrates per output port with round-robin.
- Locks each won output to its input for the whole packet.
- Drives per-input grants, per-output crossbar selects and per-output valid.
- Port order everywhere: 0 Local, 1 North, 2 East, 3 South, 4 West.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/rr_arbiter5.sv | 30 +++
 rtl/switch_allocator.sv | 107 ++++++++++
 tb/tb_switch_allocator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh router port indices and XY routing function
// Port order everywhere: 0 Local, 1 North, 2 East, 3 South, 4 West.
package noc_pkg;

   localparam int NUM_PORTS = 5;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   // Coordinates arrive zero-extended so one function serves every address width.
   function automatic logic [2:0] xy_route(input logic [15:0] dx, input logic [15:0] dy,
                                           input logic [15:0] rx, input logic [15:0] ry);
      if (dx > rx)      return PORT_EAST;
      else if (dx < rx) return PORT_WEST;
      else if (dy > ry) return PORT_NORTH;
      else if (dy < ry) return PORT_SOUTH;
      else              return PORT_LOCAL;
   endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// rtl/rr_arbiter5.sv - combinational five-way round-robin arbiter
// Searches from ptr_i upward modulo five; the first requester wins.
module rr_arbiter5
   import noc_pkg::*;
(
   input  logic [4:0] req_i,
   input  logic [2:0] ptr_i,
   output logic [4:0] gnt_o,
   output logic [2:0] idx_o,
   output logic       any_o
);

   logic [2:0] idx;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = 3'((int'(ptr_i) + k) % NUM_PORTS);
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            idx_o      = idx;
            gnt_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - XY-routed, packet-locked switch allocator for a 5-port mesh router
// Each output arbitrates only while free; a winner keeps the output until its tail transfers.
module switch_allocator
   import noc_pkg::*;
#(
   parameter int ADDRESS_SIZE = 4,
   parameter int ROUTER_X     = 0,
   parameter int ROUTER_Y     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4:0]                req,
   input  logic [4:0]                tail,
   input  logic [5*ADDRESS_SIZE-1:0] dest,
   input  logic [4:0]                out_ready,
   output logic [4:0]                gnt,
   output logic [4:0]                out_valid,
   output logic [14:0]               xbar_sel
);

   localparam int HW = ADDRESS_SIZE / 2;

   logic [4:0]      busy_q, busy_d;
   logic [4:0]      locked_q, locked_d;
   logic [4:0][2:0] owner_q, owner_d;
   logic [4:0][2:0] rr_ptr_q, rr_ptr_d;
   logic [4:0][2:0] route;
   logic [4:0][2:0] win_idx;
   logic [4:0][4:0] cand;
   logic [4:0][4:0] win_gnt;
   logic [4:0]      win_any;

   always_comb begin
      route = '0;
      cand  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         route[i] = xy_route(16'(dest[i*ADDRESS_SIZE+HW +: HW]), 16'(dest[i*ADDRESS_SIZE +: HW]),
                             16'(ROUTER_X), 16'(ROUTER_Y));
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand[o][i] = req[i] & ~locked_q[i] & ~busy_q[o] & (route[i] == 3'(o));
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter5 u_arb (
         .req_i (cand[o]),
         .ptr_i (rr_ptr_q[o]),
         .gnt_o (win_gnt[o]),
         .idx_o (win_idx[o]),
         .any_o (win_any[o])
      );
   end

   always_comb begin
      gnt       = '0;
      out_valid = '0;
      xbar_sel  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (busy_q[o]) begin
            xbar_sel[o*3 +: 3] = owner_q[o];
            if (req[owner_q[o]] && out_ready[o]) begin
               out_valid[o]       = 1'b1;
               gnt[owner_q[o]]    = 1'b1;
            end
         end
      end
   end

   // A release and a new win never coincide on one output: the freed output shows busy this cycle.
   always_comb begin
      busy_d   = busy_q;
      locked_d = locked_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (busy_q[o]) begin
            if (out_valid[o] && tail[owner_q[o]]) begin
               busy_d[o]            = 1'b0;
               locked_d[owner_q[o]] = 1'b0;
               rr_ptr_d[o]          = (owner_q[o] == 3'd4) ? 3'd0 : owner_q[o] + 3'd1;
            end
         end else if (win_any[o]) begin
            busy_d[o]  = 1'b1;
            owner_d[o] = win_idx[o];
            locked_d   = locked_d | win_gnt[o];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q   <= '0;
         locked_q <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         busy_q   <= busy_d;
         locked_q <= locked_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed self-checking bench for switch_allocator
// Router sits at (1,1); dests: Local 0x5, North 0x6, East 0x9, South 0x4, West 0x1.
module tb_switch_allocator;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req, tail, out_ready;
   logic [19:0] dest;
   logic [4:0]  gnt, out_valid;
   logic [14:0] xbar_sel;

   int n_chk  = 0;
   int n_fail = 0;

   switch_allocator #(.ADDRESS_SIZE(4), .ROUTER_X(1), .ROUTER_Y(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .tail      (tail),
      .dest      (dest),
      .out_ready (out_ready),
      .gnt       (gnt),
      .out_valid (out_valid),
      .xbar_sel  (xbar_sel)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = '0; tail = '0; dest = '0; out_ready = 5'b11111;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      req = 5'b11111;
      #2;
      n_chk++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want %b", gnt, 5'b0); end
      n_chk++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b want %b", out_valid, 5'b0); end
      n_chk++; if (xbar_sel !== 15'b0) begin n_fail++; $display("FAIL reset_xbar: got %h want %h", xbar_sel, 15'b0); end
      step();
      do_reset();
   endtask

   task automatic test_single_packet();
      step();
      req[0] = 1'b1; dest[3:0] = 4'h9;
      #1;
      n_chk++; if (gnt !== 5'b00000) begin n_fail++; $display("FAIL t1_gnt_c0: got %b want %b", gnt, 5'b0); end
      for (int c = 1; c <= 3; c++) begin
         step();
         tail[0] = (c == 3);
         #1;
         n_chk++; if (gnt !== 5'b00001) begin n_fail++; $display("FAIL t1_gnt_c%0d: got %b want %b", c, gnt, 5'b00001); end
         n_chk++; if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL t1_valid_c%0d: got %b want %b", c, out_valid, 5'b00100); end
      end
      n_chk++; if (xbar_sel[8:6] !== 3'd0) begin n_fail++; $display("FAIL t1_xbar: got %0d want %0d", xbar_sel[8:6], 0); end
      step();
      req[0] = 1'b0; tail[0] = 1'b0;
      #1;
      n_chk++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL t1_valid_c4: got %b want %b", out_valid, 5'b0); end
      // rr_ptr[2]=1 now: of inputs 0 and 1, input 1 must win
      req = 5'b00011; dest = 20'h00099;
      step();
      #1;
      n_chk++; if (gnt !== 5'b00010) begin n_fail++; $display("FAIL t1_rrptr: got %b want %b", gnt, 5'b00010); end
      do_reset();
   endtask

   task automatic test_rr_fairness();
      req = 5'b01010; dest = 20'h09090;
      #1;
      n_chk++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL t2_gnt_c0: got %b want %b", gnt, 5'b0); end
      step();
      #1;
      n_chk++; if (gnt !== 5'b00010) begin n_fail++; $display("FAIL t2_gnt_c1: got %b want %b", gnt, 5'b00010); end
      n_chk++; if (xbar_sel[8:6] !== 3'd1) begin n_fail++; $display("FAIL t2_xbar_c1: got %0d want %0d", xbar_sel[8:6], 1); end
      step();
      tail[1] = 1'b1;
      #1;
      n_chk++; if (gnt !== 5'b00010) begin n_fail++; $display("FAIL t2_gnt_c2: got %b want %b", gnt, 5'b00010); end
      step();
      req[1] = 1'b0; tail[1] = 1'b0;
      #1;
      n_chk++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL t2_idle_c3: got %b want %b", gnt, 5'b0); end
      step();
      #1;
      n_chk++; if (gnt !== 5'b01000) begin n_fail++; $display("FAIL t2_gnt_c4: got %b want %b", gnt, 5'b01000); end
      n_chk++; if (xbar_sel[8:6] !== 3'd3) begin n_fail++; $display("FAIL t2_xbar_c4: got %0d want %0d", xbar_sel[8:6], 3); end
      step();
      tail[3] = 1'b1;
      #1;
      n_chk++; if (gnt !== 5'b01000) begin n_fail++; $display("FAIL t2_gnt_c5: got %b want %b", gnt, 5'b01000); end
      step();
      req = 5'b01010; tail = '0;
      step();
      #1;
      n_chk++; if (gnt !== 5'b00010) begin n_fail++; $display("FAIL t2_rewin: got %b want %b", gnt, 5'b00010); end
      do_reset();
   endtask

   task automatic test_all_ports();
      req = 5'b11111; tail = 5'b11111;
      dest = {4'h5, 4'h1, 4'h4, 4'h9, 4'h6};
      step();
      #1;
      n_chk++; if (gnt !== 5'b11111) begin n_fail++; $display("FAIL t3_gnt_c1: got %b want %b", gnt, 5'b11111); end
      n_chk++; if (out_valid !== 5'b11111) begin n_fail++; $display("FAIL t3_valid_c1: got %b want %b", out_valid, 5'b11111); end
      n_chk++; if (xbar_sel !== {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}) begin n_fail++; $display("FAIL t3_xbar: got %h want %h", xbar_sel, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}); end
      step();
      #1;
      n_chk++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL t3_release_c2: got %b want %b", gnt, 5'b0); end
      step();
      #1;
      n_chk++; if (gnt !== 5'b11111) begin n_fail++; $display("FAIL t3_regrant_c3: got %b want %b", gnt, 5'b11111); end
      do_reset();
   endtask

   task automatic test_stall();
      req[2] = 1'b1; dest[11:8] = 4'h1;
      step();
      #1;
      n_chk++; if (gnt !== 5'b00100) begin n_fail++; $display("FAIL t4_gnt_c1: got %b want %b", gnt, 5'b00100); end
      req[0] = 1'b1; dest[3:0] = 4'h1;
      out_ready[4] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         #1;
         n_chk++; if (gnt !== 5'b0 || out_valid !== 5'b0) begin n_fail++; $display("FAIL t4_stall_%0d: got gnt %b valid %b want 0", c, gnt, out_valid); end
         n_chk++; if (xbar_sel[14:12] !== 3'd2) begin n_fail++; $display("FAIL t4_owner_%0d: got %0d want %0d", c, xbar_sel[14:12], 2); end
      end
      step();
      out_ready[4] = 1'b1;
      #1;
      n_chk++; if (gnt !== 5'b00100 || out_valid !== 5'b10000) begin n_fail++; $display("FAIL t4_resume: got gnt %b valid %b want 00100 10000", gnt, out_valid); end
      step();
      tail[2] = 1'b1;
      step();
      req[2] = 1'b0; tail[2] = 1'b0;
      step();
      #1;
      n_chk++; if (gnt !== 5'b00001) begin n_fail++; $display("FAIL t4_next_owner: got %b want %b", gnt, 5'b00001); end
      do_reset();
   endtask

   task automatic test_async_reset();
      req[1] = 1'b1; tail[1] = 1'b1; dest[7:4] = 4'h9;
      step();
      #1;
      n_chk++; if (gnt !== 5'b00010) begin n_fail++; $display("FAIL t5_first: got %b want %b", gnt, 5'b00010); end
      step();
      req[1] = 1'b0; tail[1] = 1'b0;
      req[3] = 1'b1; dest[15:12] = 4'h9;
      step();
      #1;
      n_chk++; if (gnt !== 5'b01000) begin n_fail++; $display("FAIL t5_locked: got %b want %b", gnt, 5'b01000); end
      #2;
      rst = 1'b0;
      #1;
      n_chk++; if (gnt !== 5'b0 || out_valid !== 5'b0 || xbar_sel !== 15'b0) begin n_fail++; $display("FAIL t5_async: got gnt %b valid %b xbar %h want 0", gnt, out_valid, xbar_sel); end
      step();
      rst = 1'b1;
      req[0] = 1'b1; dest[3:0] = 4'h9;
      #1;
      n_chk++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL t5_rearb_c0: got %b want %b", gnt, 5'b0); end
      step();
      #1;
      n_chk++; if (gnt !== 5'b00001) begin n_fail++; $display("FAIL t5_rearb: got %b want %b", gnt, 5'b00001); end
      do_reset();
   endtask

   task automatic test_dest_change();
      req[0] = 1'b1; dest[3:0] = 4'h9;
      step();
      #1;
      n_chk++; if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL t6_valid_c1: got %b want %b", out_valid, 5'b00100); end
      step();
      dest[3:0] = 4'h1;
      #1;
      n_chk++; if (gnt !== 5'b00001 || out_valid !== 5'b00100) begin n_fail++; $display("FAIL t6_c2: got gnt %b valid %b want 00001 00100", gnt, out_valid); end
      step();
      tail[0] = 1'b1;
      #1;
      n_chk++; if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL t6_tail: got %b want %b", out_valid, 5'b00100); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_rr_fairness();
      test_all_ports();
      test_stall();
      test_async_reset();
      test_dest_change();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
